// File: rtl/wavelet_coef_serializer.sv
// rtl/wavelet_coef_serializer.sv - merges per-level wavelet coefficient vectors into one word stream
//
// Each decomposition level has its own vector FIFO. Queued vectors are
// serialized one fp32 lane per accepted beat. The highest non-empty level
// wins, and it is chosen only when a new vector starts.
//
// Ports:
//   clk_312_5   sole clock, rising edge
//   rst         asynchronous active-high reset
//   in_valid    per-level push strobe (bit k-1 = level k)
//   in_data     per-level vector slices, LANES_L1*DW bits per level, lane 0 in LSBs
//   dout_ready  downstream accepts the current word
//   dout        current coefficient word
//   dout_valid  dout and tags are valid
//   dout_level  level number 1..LEVELS of the current word
//   dout_lane   lane index of the current word
//   dout_last   current word is the final lane of its vector
//   ovf         sticky per-level overflow flags

module wavelet_coef_serializer #(
    parameter int LEVELS   = 5,
    parameter int LANES_L1 = 8,
    parameter int DW       = 32,
    parameter int DEPTH    = 4
) (
    input  logic                            clk_312_5,
    input  logic                            rst,
    input  logic [LEVELS-1:0]               in_valid,
    input  logic [LEVELS*LANES_L1*DW-1:0]   in_data,
    input  logic                            dout_ready,
    output logic [DW-1:0]                   dout,
    output logic                            dout_valid,
    output logic [3:0]                      dout_level,
    output logic [3:0]                      dout_lane,
    output logic                            dout_last,
    output logic [LEVELS-1:0]               ovf
);

    localparam int VW = LANES_L1 * DW;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    // Index of the final lane for a 0-based level: max(1, LANES_L1 >> k0) - 1.
    function automatic logic [3:0] last_lane_of(input int k0);
        int n;
        n = LANES_L1 >> k0;
        if (n < 1) n = 1;
        return 4'(n - 1);
    endfunction

    // Every level stores a full-width slot. Lanes above NL(k) are never read.
    logic [VW-1:0] mem [LEVELS][DEPTH];
    logic [PW:0]   wr_ptr [LEVELS];
    logic [PW:0]   rd_ptr [LEVELS];

    logic [LEVELS-1:0] empty;
    logic [LEVELS-1:0] full;
    logic [LEVELS-1:0] push;
    logic [LW-1:0]     win;
    logic              any_ne;
    logic              advance;
    logic              take;
    logic [VW-1:0]     rd_data;
    logic [3:0]        next_lane;

    state_t        state;
    logic [VW-1:0] vec_reg;
    logic [3:0]    last_lane;

    // Fullness is taken from pre-edge pointers, so a same-edge pop never frees room for a push.
    always_comb begin
        empty = '0;
        full  = '0;
        push  = '0;
        for (int k = 0; k < LEVELS; k++) begin
            empty[k] = (wr_ptr[k] == rd_ptr[k]);
            full[k]  = (wr_ptr[k][PW] != rd_ptr[k][PW]) &&
                       (wr_ptr[k][PW-1:0] == rd_ptr[k][PW-1:0]);
            push[k]  = in_valid[k] && !full[k];
        end
    end

    // The scan runs in ascending order, so the highest non-empty level is the last one written.
    always_comb begin
        win    = '0;
        any_ne = 1'b0;
        for (int k = 0; k < LEVELS; k++) begin
            if (!empty[k]) begin
                win    = LW'(k);
                any_ne = 1'b1;
            end
        end
    end

    assign advance   = dout_valid && dout_ready;
    // A new vector is loaded from idle, or on the same edge the last lane is accepted.
    assign take      = any_ne && ((state == IDLE) || (advance && dout_last));
    assign rd_data   = mem[win][rd_ptr[win][PW-1:0]];
    assign next_lane = dout_lane + 4'd1;

    always_ff @(posedge clk_312_5) begin
        for (int k = 0; k < LEVELS; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k][PW-1:0]] <= in_data[k*VW +: VW];
            end
        end
    end

    always_ff @(posedge clk_312_5 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vec_reg    <= '0;
            last_lane  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_level <= '0;
            dout_lane  <= '0;
            dout_last  <= 1'b0;
            ovf        <= '0;
            for (int k = 0; k < LEVELS; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LEVELS; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + 1'b1;
                end
                if (in_valid[k] && full[k]) begin
                    ovf[k] <= 1'b1;
                end
                if (take && (win == LW'(k))) begin
                    rd_ptr[k] <= rd_ptr[k] + 1'b1;
                end
            end

            if (take) begin
                state      <= SEND;
                vec_reg    <= rd_data;
                dout       <= rd_data[DW-1:0];
                dout_valid <= 1'b1;
                dout_level <= 4'(win) + 4'd1;
                dout_lane  <= '0;
                last_lane  <= last_lane_of(int'(win));
                dout_last  <= (last_lane_of(int'(win)) == 4'd0);
            end else if ((state == SEND) && advance) begin
                if (dout_last) begin
                    state      <= IDLE;
                    dout_valid <= 1'b0;
                    dout_last  <= 1'b0;
                end else begin
                    dout_lane <= next_lane;
                    dout      <= vec_reg[next_lane*DW +: DW];
                    dout_last <= (next_lane == last_lane);
                end
            end
        end
    end

endmodule

// File: tb/tb_wavelet_coef_serializer.sv
// tb/tb_wavelet_coef_serializer.sv - self-checking bench for wavelet_coef_serializer

module tb_wavelet_coef_serializer;

    localparam int L  = 5;
    localparam int N1 = 8;
    localparam int DW = 32;
    localparam int D  = 4;
    localparam int VW = N1 * DW;

    typedef logic [VW-1:0] vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [L-1:0]      in_valid;
    logic [L*VW-1:0]   in_data;
    logic              dout_ready;
    logic [DW-1:0]     dout;
    logic              dout_valid;
    logic [3:0]        dout_level;
    logic [3:0]        dout_lane;
    logic              dout_last;
    logic [L-1:0]      ovf;

    wavelet_coef_serializer #(.LEVELS(L), .LANES_L1(N1), .DW(DW), .DEPTH(D)) dut (
        .clk_312_5  (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_level (dout_level),
        .dout_lane  (dout_lane),
        .dout_last  (dout_last),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: one queue per level, plus the vector being sent.
    vec_t       mq [L][$];
    vec_t       m_vec;
    int         m_level;
    int         m_lane;
    bit         m_valid;
    logic [L-1:0] m_ovf;
    bit         fsnap [L];
    bit         found;

    // Log of accepted beats, used by the directed literal checks.
    logic [31:0] lg_d [$];
    int          lg_lvl [$];
    int          lg_lane [$];
    int          lg_cyc [$];
    bit          lg_last [$];

    function automatic int nl(input int lvl);
        int n;
        n = N1 >> (lvl - 1);
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int m_pending();
        int s;
        s = m_valid ? 1 : 0;
        for (int k = 0; k < L; k++) s += mq[k].size();
        return s;
    endfunction

    task automatic lg_clear();
        lg_d.delete(); lg_lvl.delete(); lg_lane.delete(); lg_cyc.delete(); lg_last.delete();
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < L; k++) mq[k].delete();
            m_valid = 1'b0;
            m_level = 0;
            m_lane  = 0;
            m_ovf   = '0;
        end else begin
            cyc++;
            if (dout_valid && dout_ready) begin
                lg_d.push_back(dout);
                lg_lvl.push_back(int'(dout_level));
                lg_lane.push_back(int'(dout_lane));
                lg_last.push_back(dout_last);
                lg_cyc.push_back(cyc);
            end
            for (int k = 0; k < L; k++) fsnap[k] = (mq[k].size() >= D);
            if (m_valid && dout_ready) begin
                if (m_lane < nl(m_level) - 1) m_lane++;
                else m_valid = 1'b0;
            end
            if (!m_valid) begin
                found = 1'b0;
                for (int k = L - 1; k >= 0; k--) begin
                    if (!found && mq[k].size() > 0) begin
                        m_vec   = mq[k].pop_front();
                        m_level = k + 1;
                        m_lane  = 0;
                        m_valid = 1'b1;
                        found   = 1'b1;
                    end
                end
            end
            for (int k = 0; k < L; k++) begin
                if (in_valid[k]) begin
                    if (fsnap[k]) m_ovf[k] = 1'b1;
                    else mq[k].push_back(in_data[k*VW +: VW]);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en && !rst) begin
            check("cmp_valid", dout_valid, m_valid);
            check("cmp_ovf", ovf, m_ovf);
            if (m_valid) begin
                check("cmp_dout", dout, m_vec[m_lane*DW +: DW]);
                check("cmp_level", dout_level, m_level);
                check("cmp_lane", dout_lane, m_lane);
                check("cmp_last", dout_last, (m_lane == nl(m_level) - 1));
            end
        end
    end

    task automatic clr_in();
        in_valid = '0;
        in_data  = '0;
    endtask

    task automatic set_lane(input int lvl, input int lane, input logic [31:0] v);
        in_data[(lvl-1)*VW + lane*DW +: DW] = v;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((dout_valid || m_pending() > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_bound", (n < 300), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        dout_ready = 1'b1;
        in_valid   = '1;
        for (int i = 0; i < L*N1; i++) in_data[i*DW +: DW] = 32'hDEAD0000 + i;
        #1 rst = 1'b1;

        // Reset holds every output at zero even with all push strobes high.
        repeat (3) begin
            @(negedge clk);
            check("rst_dout", dout, 0);
            check("rst_valid", dout_valid, 0);
            check("rst_level", dout_level, 0);
            check("rst_lane", dout_lane, 0);
            check("rst_last", dout_last, 0);
            check("rst_ovf", ovf, 0);
        end
        rst = 1'b0;
        clr_in();
        chk_en = 1'b1;
        @(negedge clk);

        // Single level-1 vector: latency and lane order.
        lg_clear();
        for (int i = 0; i < 8; i++) set_lane(1, i, 32'h3F800000 + i);
        in_valid = 5'b00001;
        @(posedge clk); #1;
        check("t1_valid_at_n", dout_valid, 0);
        @(negedge clk);
        clr_in();
        @(posedge clk); #1;
        check("t1_valid_at_n1", dout_valid, 1);
        check("t1_first_word", dout, 32'h3F800000);
        drain();
        check("t1_count", lg_d.size(), 8);
        if (lg_d.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("t1_data", lg_d[i], 32'h3F800000 + i);
                check("t1_lane", lg_lane[i], i);
                check("t1_level", lg_lvl[i], 1);
                check("t1_last", lg_last[i], (i == 7));
            end
        end

        // Level 5 wins over level 1 pushed on the same edge, with no gap between the vectors.
        lg_clear();
        for (int i = 0; i < 8; i++) set_lane(1, i, 32'h100 + i);
        set_lane(5, 0, 32'hABCD0005);
        in_valid = 5'b10001;
        @(negedge clk);
        clr_in();
        drain();
        check("t2_count", lg_d.size(), 9);
        if (lg_d.size() == 9) begin
            check("t2_l5_data", lg_d[0], 32'hABCD0005);
            check("t2_l5_level", lg_lvl[0], 5);
            check("t2_l5_lane", lg_lane[0], 0);
            check("t2_l5_last", lg_last[0], 1);
            for (int i = 1; i < 9; i++) begin
                check("t2_l1_data", lg_d[i], 32'h100 + i - 1);
                check("t2_l1_level", lg_lvl[i], 1);
                check("t2_l1_lane", lg_lane[i], i - 1);
                check("t2_l1_last", lg_last[i], (i == 8));
                check("t2_no_gap", lg_cyc[i], lg_cyc[0] + i);
            end
        end

        // Backpressure while lane 3 is presented.
        lg_clear();
        for (int i = 0; i < 8; i++) set_lane(1, i, 32'h200 + i);
        in_valid = 5'b00001;
        @(negedge clk);
        clr_in();
        n = 0;
        while (!(dout_valid && dout_lane == 4'd3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t3_reach_lane3", (n < 50), 1);
        dout_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3_hold_valid", dout_valid, 1);
            check("t3_hold_dout", dout, 32'h203);
            check("t3_hold_lane", dout_lane, 3);
            check("t3_hold_last", dout_last, 0);
        end
        dout_ready = 1'b1;
        drain();
        check("t3_count", lg_d.size(), 8);
        if (lg_d.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("t3_data", lg_d[i], 32'h200 + i);
                check("t3_lane", lg_lane[i], i);
            end
        end

        // Overflow on level 2: five vectors fit (four in the FIFO, one in the output register), the sixth is dropped.
        lg_clear();
        dout_ready = 1'b0;
        for (int v = 0; v < 6; v++) begin
            if (v == 5) check("t4_ovf_before_6th", ovf, 5'b00000);
            clr_in();
            for (int i = 0; i < 4; i++) set_lane(2, i, 32'h3000 + v*16 + i);
            in_valid = 5'b00010;
            @(negedge clk);
        end
        clr_in();
        check("t4_ovf_after_6th", ovf, 5'b00010);
        dout_ready = 1'b1;
        drain();
        check("t4_count", lg_d.size(), 20);
        if (lg_d.size() == 20) begin
            for (int v = 0; v < 5; v++) begin
                for (int i = 0; i < 4; i++) begin
                    check("t4_data", lg_d[v*4+i], 32'h3000 + v*16 + i);
                    check("t4_level", lg_lvl[v*4+i], 2);
                    check("t4_lane", lg_lane[v*4+i], i);
                    check("t4_last", lg_last[v*4+i], (i == 3));
                end
            end
        end

        // Reset in the middle of a vector while two level-3 vectors are queued.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_ovf_cleared", ovf, 0);
        for (int i = 0; i < 8; i++) set_lane(1, i, 32'h400 + i);
        in_valid = 5'b00001;
        @(negedge clk);
        clr_in();
        set_lane(3, 0, 32'h500); set_lane(3, 1, 32'h501);
        in_valid = 5'b00100;
        @(negedge clk);
        clr_in();
        set_lane(3, 0, 32'h600); set_lane(3, 1, 32'h601);
        in_valid = 5'b00100;
        @(negedge clk);
        clr_in();
        n = 0;
        while (!(dout_valid && dout_lane == 4'd4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_lane4", (n < 50), 1);
        check("t5_lane4_data", dout, 32'h404);
        rst = 1'b1;
        #1;
        check("t5_valid_async", dout_valid, 0);
        check("t5_dout_async", dout, 0);
        check("t5_lane_async", dout_lane, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lg_clear();
        repeat (10) begin
            @(negedge clk);
            check("t5_no_residual", dout_valid, 0);
        end
        check("t5_log_empty", lg_d.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wavelet_coef_serializer.md
WAVELET_COEF_SERIALIZER -- requirements
Module: wavelet_coef_serializer

Interface
REQ-001 Parameter LEVELS, default 5, number of decomposition levels merged (legal 1..8).
REQ-002 Parameter LANES_L1, default 8, fp32 lanes per level-1 vector (power of 2, 1..16); level k (1-based) carries NL(k) = max(1, LANES_L1>>(k-1)) lanes.
REQ-003 Parameter DW, default 32, word width (IEEE-754 single, passed through untouched).
REQ-004 Parameter DEPTH, default 4, vector entries per level FIFO (power of 2, >=2).
REQ-005 Port clk_312_5  input  1  sole clock; all state changes on its rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Port in_valid  input  LEVELS  bit k-1 high: level-k vector on in_data is valid this cycle.
REQ-008 Port in_data  input  LEVELS*LANES_L1*DW  level k occupies slice [(k-1)*LANES_L1*DW +: NL(k)*DW], lane 0 in least-significant DW bits; unused upper bits ignored.
REQ-009 Port dout_ready  input  1  downstream accepts dout this cycle.
REQ-010 Port dout  output  DW  current coefficient word.
REQ-011 Port dout_valid  output  1  dout and tags valid.
REQ-012 Port dout_level  output  4  level number 1..LEVELS of current word.
REQ-013 Port dout_lane  output  4  lane index 0..NL-1 of current word.
REQ-014 Port dout_last  output  1  high on lane NL-1 of the vector.
REQ-015 Port ovf  output  LEVELS  sticky per-level overflow flags.

Function
REQ-016 One FIFO per level, width NL(k)*DW, DEPTH entries; in_valid[k-1] high at an edge pushes the level-k vector if that FIFO is not full.
REQ-017 Fullness is evaluated before any same-edge pop; a push on a full FIFO is dropped even if a pop occurs that edge, and sets ovf[k-1], cleared only by rst.
REQ-018 State machine IDLE/SEND; IDLE: if any FIFO non-empty, pop the winner into the output vector register, dout_valid=1, lane=0, go SEND; else stay.
REQ-019 Arbitration is fixed priority, highest level number first, decided only at vector boundaries; a vector is never interleaved with another.
REQ-020 SEND: on dout_valid & dout_ready, lane advances; on acceptance of the last lane, pop next winner same edge (no bubble) if any FIFO non-empty, else dout_valid=0, go IDLE.
REQ-021 While dout_valid & !dout_ready, dout, dout_level, dout_lane, dout_last are held stable.
REQ-022 Latency: vector sampled at edge N into empty block in IDLE -> dout_valid high after edge N+1 (lane 0).
REQ-023 Storage capacity per level is DEPTH vectors plus one vector in the output register.
REQ-024 Simultaneous pushes on several levels in one edge are all accepted independently.
REQ-025 dout_lane/dout_level zero-extended to 4 bits; NL(k)=1 levels assert dout_last on every word.

Reset
REQ-026 rst high asynchronously forces: FIFOs empty, state IDLE, dout=0, dout_valid=0, dout_level=0, dout_lane=0, dout_last=0, ovf=0.
REQ-027 Reset mid-vector discards the partial vector and all queued vectors; no residual word appears after release.
REQ-028 First push is accepted at the first rising edge with rst low.

Verification (LEVELS=5, LANES_L1=8, DEPTH=4)
REQ-029 rst=1 with in_valid=all ones -> all outputs 0, ovf=0 throughout.
REQ-030 One L1 vector lanes 0x3F800000+i, dout_ready=1 -> valid after edge N+1, 8 consecutive words lane 0..7, level 1, dout_last only on lane 7.
REQ-031 L1 and L5 pushed same edge -> one L5 word (level 5, lane 0, last=1) first, then 8 L1 words with no gap.
REQ-032 dout_ready low 3 cycles while lane 3 of L1 presented -> dout/tags stable 3 cycles, then lanes 3..7 delivered, none lost or duplicated.
REQ-033 dout_ready=0, six L2 vectors pushed on consecutive edges -> ovf[1]=1 after sixth, other ovf bits 0; drain yields exactly first five vectors in order, 4 words each.
REQ-034 rst pulsed during lane 4 of L1 vector with two L3 vectors queued -> dout_valid 0 immediately; after release with no pushes, dout_valid stays 0.
